// File: rtl/bel_fft_csr_pkg.sv
// Register map, field positions and size limits shared by the FFT CSR block.
package bel_fft_csr_pkg;

    localparam int unsigned ADR_CTRL   = 0;
    localparam int unsigned ADR_STATUS = 1;
    localparam int unsigned ADR_SIZE   = 2;
    localparam int unsigned ADR_SRC    = 3;
    localparam int unsigned ADR_DST    = 4;
    localparam int unsigned ADR_ID     = 5;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_IE    = 1;
    localparam int unsigned CTRL_INV   = 2;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_CERR  = 2;
    localparam int unsigned STAT_OVR   = 3;

    localparam int unsigned MIN_LOG2   = 3;
    localparam int unsigned SIZE_W     = 4;

endpackage

// File: rtl/bel_fft_csr.sv
// FFT job control/status registers on the internal slave bus.
// Every strobe is answered with a registered ack one cycle later.
module bel_fft_csr
    import bel_fft_csr_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 4,
    parameter int unsigned MAX_LOG2 = 10,
    parameter logic [31:0] CORE_ID  = 32'hBE1F_0100
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [AWIDTH-1:0]   adr_i,
    input  logic [DWIDTH-1:0]   dat_i,
    input  logic [DWIDTH/8-1:0] bsel_i,
    input  logic                wr_i,
    input  logic                rd_i,
    output logic [DWIDTH-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                start_o,
    output logic                inverse_o,
    output logic [SIZE_W-1:0]   size_log2_o,
    output logic [DWIDTH-1:0]   src_adr_o,
    output logic [DWIDTH-1:0]   dst_adr_o,
    input  logic                busy_i,
    input  logic                done_i,
    input  logic                cerr_i,
    output logic                irq_o
);

    localparam int unsigned NB = DWIDTH / 8;

    function automatic logic [DWIDTH-1:0] bmask(input logic [DWIDTH-1:0] old_v,
                                                 input logic [DWIDTH-1:0] new_v,
                                                 input logic [NB-1:0]     be);
        logic [DWIDTH-1:0] r;
        r = old_v;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    logic              ie_q, ie_d, inv_q, inv_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [DWIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic              done_q, done_d, cerr_q, cerr_d, ovr_q, ovr_d;
    logic              ack_q, ack_d, err_q, err_d, start_q, start_d, irq_q, irq_d;
    logic [DWIDTH-1:0] dat_q, dat_d;

    logic              wr_en, rd_en;
    logic              is_ctrl, is_stat, is_size, is_src, is_dst, is_id, mapped;
    logic              done_clr, cerr_clr, ovr_clr, ovr_set;
    logic [7:0]        size_byte;

    always_comb begin
        ie_d      = ie_q;
        inv_d     = inv_q;
        size_d    = size_q;
        src_d     = src_q;
        dst_d     = dst_q;
        ack_d     = wr_i | rd_i;
        err_d     = 1'b0;
        dat_d     = '0;
        start_d   = 1'b0;
        done_clr  = 1'b0;
        cerr_clr  = 1'b0;
        ovr_clr   = 1'b0;
        ovr_set   = 1'b0;
        size_byte = dat_i[7:0];

        wr_en   = wr_i & ~rd_i;
        rd_en   = rd_i & ~wr_i;
        is_ctrl = (adr_i == AWIDTH'(ADR_CTRL));
        is_stat = (adr_i == AWIDTH'(ADR_STATUS));
        is_size = (adr_i == AWIDTH'(ADR_SIZE));
        is_src  = (adr_i == AWIDTH'(ADR_SRC));
        is_dst  = (adr_i == AWIDTH'(ADR_DST));
        is_id   = (adr_i == AWIDTH'(ADR_ID));
        mapped  = is_ctrl | is_stat | is_size | is_src | is_dst | is_id;

        if ((wr_i & rd_i) | ((wr_i | rd_i) & ~mapped)) err_d = 1'b1;

        if (wr_en && mapped) begin
            if (is_ctrl && bsel_i[0]) begin
                ie_d  = dat_i[CTRL_IE];
                inv_d = dat_i[CTRL_INV];
                // A start request while the core runs or a pulse is already out is recorded as overrun.
                if (dat_i[CTRL_START]) begin
                    if (busy_i || start_q) ovr_set = 1'b1;
                    else                   start_d = 1'b1;
                end
            end
            if (is_stat && bsel_i[0]) begin
                done_clr = dat_i[STAT_DONE];
                cerr_clr = dat_i[STAT_CERR];
                ovr_clr  = dat_i[STAT_OVR];
            end
            if (is_size && bsel_i[0]) begin
                if (size_byte < 8'(MIN_LOG2) || size_byte > 8'(MAX_LOG2)) err_d  = 1'b1;
                else                                                      size_d = dat_i[SIZE_W-1:0];
            end
            if (is_src) src_d = bmask(src_q, dat_i, bsel_i) & ~DWIDTH'(3);
            if (is_dst) dst_d = bmask(dst_q, dat_i, bsel_i) & ~DWIDTH'(3);
            if (is_id)  err_d = 1'b1;
        end

        if (rd_en) begin
            if (is_ctrl) begin
                dat_d[CTRL_IE]  = ie_q;
                dat_d[CTRL_INV] = inv_q;
            end
            if (is_stat) begin
                dat_d[STAT_BUSY] = busy_i;
                dat_d[STAT_DONE] = done_q;
                dat_d[STAT_CERR] = cerr_q;
                dat_d[STAT_OVR]  = ovr_q;
            end
            if (is_size) dat_d[SIZE_W-1:0] = size_q;
            if (is_src)  dat_d = src_q;
            if (is_dst)  dat_d = dst_q;
            if (is_id)   dat_d = DWIDTH'(CORE_ID);
        end

        // Set events take priority over a same-cycle write-1-clear.
        done_d = (done_q & ~done_clr) | done_i;
        cerr_d = (cerr_q & ~cerr_clr) | cerr_i;
        ovr_d  = (ovr_q  & ~ovr_clr)  | ovr_set;
        irq_d  = ie_q & (done_q | cerr_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ie_q    <= 1'b0;
            inv_q   <= 1'b0;
            size_q  <= SIZE_W'(MIN_LOG2);
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
            cerr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ie_q    <= ie_d;
            inv_q   <= inv_d;
            size_q  <= size_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            done_q  <= done_d;
            cerr_q  <= cerr_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            start_q <= start_d;
            irq_q   <= irq_d;
            dat_q   <= dat_d;
        end
    end

    assign dat_o       = dat_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign start_o     = start_q;
    assign irq_o       = irq_q;
    assign inverse_o   = inv_q;
    assign size_log2_o = size_q;
    assign src_adr_o   = src_q;
    assign dst_adr_o   = dst_q;

endmodule

// File: tb/tb_bel_fft_csr.sv
// Directed bench for the FFT CSR block with hand-computed expectations.
module tb_bel_fft_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    logic        wr, rd;
    logic [31:0] dat_o;
    logic        ack_o, err_o, start_o, inverse_o, irq_o;
    logic [3:0]  size_o;
    logic [31:0] src_o, dst_o;
    logic        busy, done, cerr;

    int checks = 0;
    int errors = 0;

    logic [31:0] dat_s;
    logic        ack_s, err_s, start_s;

    always #5 clk = ~clk;

    bel_fft_csr #(
        .DWIDTH  (32),
        .AWIDTH  (4),
        .MAX_LOG2(10),
        .CORE_ID (32'hBE1F_0100)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .adr_i      (adr),
        .dat_i      (dat),
        .bsel_i     (bsel),
        .wr_i       (wr),
        .rd_i       (rd),
        .dat_o      (dat_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .start_o    (start_o),
        .inverse_o  (inverse_o),
        .size_log2_o(size_o),
        .src_adr_o  (src_o),
        .dst_adr_o  (dst_o),
        .busy_i     (busy),
        .done_i     (done),
        .cerr_i     (cerr),
        .irq_o      (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic w, input logic r, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        wr = w; rd = r; adr = a; dat = d; bsel = be;
        step();
        ack_s = ack_o; err_s = err_o; dat_s = dat_o; start_s = start_o;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        acc(1'b0, 1'b1, a, 32'h0, 4'hF);
        chk({tag, ".ack"}, {31'b0, ack_s}, 32'd1);
        chk({tag, ".err"}, {31'b0, err_s}, 32'd0);
        chk({tag, ".dat"}, dat_s, exp);
    endtask

    task automatic wr_chk(input string tag, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic experr);
        acc(1'b1, 1'b0, a, d, be);
        chk({tag, ".ack"}, {31'b0, ack_s}, 32'd1);
        chk({tag, ".err"}, {31'b0, err_s}, {31'b0, experr});
        chk({tag, ".dat"}, dat_s, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; dat = '0; bsel = '0; wr = 1'b0; rd = 1'b0;
        busy = 1'b0; done = 1'b0; cerr = 1'b0;
        step(); step(); step();
        chk("rst.ack",   {31'b0, ack_o},   32'd0);
        chk("rst.err",   {31'b0, err_o},   32'd0);
        chk("rst.start", {31'b0, start_o}, 32'd0);
        chk("rst.irq",   {31'b0, irq_o},   32'd0);
        chk("rst.dat",   dat_o,            32'h0);
        chk("rst.size",  {28'b0, size_o},  32'd3);
        rst_n = 1'b1;
        step();

        // Back-to-back reads of ID, SIZE, CTRL.
        rd = 1'b1; adr = 4'd5; bsel = 4'hF;
        step();
        chk("b2b.id.ack", {31'b0, ack_o}, 32'd1);
        chk("b2b.id.dat", dat_o, 32'hBE1F_0100);
        chk("b2b.id.err", {31'b0, err_o}, 32'd0);
        adr = 4'd2;
        step();
        chk("b2b.size.ack", {31'b0, ack_o}, 32'd1);
        chk("b2b.size.dat", dat_o, 32'd3);
        adr = 4'd0;
        step();
        chk("b2b.ctrl.ack", {31'b0, ack_o}, 32'd1);
        chk("b2b.ctrl.dat", dat_o, 32'd0);
        rd = 1'b0;
        step();
        chk("b2b.idle.ack", {31'b0, ack_o}, 32'd0);

        // Byte-masked address registers, low two bits forced to zero.
        wr_chk("src.w0", 4'd3, 32'h1000_0003, 4'b0011, 1'b0);
        rd_chk("src.r0", 4'd3, 32'h0000_0000);
        wr_chk("src.w1", 4'd3, 32'h1000_0003, 4'hF, 1'b0);
        rd_chk("src.r1", 4'd3, 32'h1000_0000);
        chk("src.out", src_o, 32'h1000_0000);
        wr_chk("dst.w", 4'd4, 32'hDEAD_BEEF, 4'b1100, 1'b0);
        chk("dst.out", dst_o, 32'hDEAD_0000);

        // START pulse, then overrun while busy.
        wr_chk("start.w", 4'd0, 32'h7, 4'hF, 1'b0);
        chk("start.pulse", {31'b0, start_s}, 32'd1);
        step();
        chk("start.one", {31'b0, start_o}, 32'd0);
        chk("start.inv", {31'b0, inverse_o}, 32'd1);
        rd_chk("ctrl.r", 4'd0, 32'h6);
        busy = 1'b1;
        wr_chk("busy.w", 4'd0, 32'h7, 4'hF, 1'b0);
        chk("busy.nopulse", {31'b0, start_s}, 32'd0);
        rd_chk("busy.status", 4'd1, 32'h9);
        busy = 1'b0;
        wr_chk("ovr.clr", 4'd1, 32'h8, 4'h1, 1'b0);

        // Second START on the cycle right after a pulse is an overrun.
        wr = 1'b1; adr = 4'd0; dat = 32'h7; bsel = 4'hF;
        step();
        chk("pend.pulse1", {31'b0, start_o}, 32'd1);
        step();
        wr = 1'b0;
        chk("pend.ack2", {31'b0, ack_o}, 32'd1);
        chk("pend.nopulse", {31'b0, start_o}, 32'd0);
        rd_chk("pend.status", 4'd1, 32'h8);
        wr_chk("ovr.clr2", 4'd1, 32'h8, 4'h1, 1'b0);

        // START byte disabled: nothing happens.
        wr_chk("nobe.w", 4'd0, 32'h7, 4'b1110, 1'b0);
        chk("nobe.nopulse", {31'b0, start_s}, 32'd0);
        rd_chk("nobe.ctrl", 4'd0, 32'h6);
        rd_chk("nobe.status", 4'd1, 32'h0);

        // DONE sticky and interrupt timing.
        done = 1'b1;
        step();
        done = 1'b0;
        chk("done.irq0", {31'b0, irq_o}, 32'd0);
        step();
        chk("done.irq1", {31'b0, irq_o}, 32'd1);
        done = 1'b1;
        wr_chk("done.w1c_set", 4'd1, 32'h2, 4'h1, 1'b0);
        done = 1'b0;
        rd_chk("done.setwins", 4'd1, 32'h2);
        chk("done.irq_hold", {31'b0, irq_o}, 32'd1);
        wr_chk("done.w1c", 4'd1, 32'h2, 4'h1, 1'b0);
        chk("done.irq_n1", {31'b0, irq_o}, 32'd1);
        step();
        chk("done.irq_n2", {31'b0, irq_o}, 32'd0);
        rd_chk("done.cleared", 4'd1, 32'h0);

        // CERR sticky, then IE clear drops the interrupt.
        cerr = 1'b1;
        step();
        cerr = 1'b0;
        rd_chk("cerr.status", 4'd1, 32'h4);
        chk("cerr.irq", {31'b0, irq_o}, 32'd1);
        wr_chk("ie.clr", 4'd0, 32'h4, 4'h1, 1'b0);
        chk("ie.irq_n1", {31'b0, irq_o}, 32'd1);
        step();
        chk("ie.irq_n2", {31'b0, irq_o}, 32'd0);
        wr_chk("cerr.w1c", 4'd1, 32'h4, 4'h1, 1'b0);

        // Error responses.
        wr_chk("size.lo", 4'd2, 32'd2, 4'hF, 1'b1);
        wr_chk("size.hi", 4'd2, 32'd11, 4'hF, 1'b1);
        acc(1'b0, 1'b1, 4'd9, 32'h0, 4'hF);
        chk("unmap.ack", {31'b0, ack_s}, 32'd1);
        chk("unmap.err", {31'b0, err_s}, 32'd1);
        wr_chk("id.w", 4'd5, 32'h1234_5678, 4'hF, 1'b1);
        acc(1'b1, 1'b1, 4'd2, 32'd5, 4'hF);
        chk("rdwr.ack", {31'b0, ack_s}, 32'd1);
        chk("rdwr.err", {31'b0, err_s}, 32'd1);
        chk("rdwr.dat", dat_s, 32'h0);
        rd_chk("size.keep", 4'd2, 32'd3);
        wr_chk("size.max", 4'd2, 32'd10, 4'h1, 1'b0);
        chk("size.out", {28'b0, size_o}, 32'd10);
        wr_chk("size.nobe", 4'd2, 32'd5, 4'b1110, 1'b0);
        rd_chk("size.nobe_r", 4'd2, 32'd10);

        // Reset coincident with a read strobe drops the ack.
        rd = 1'b1; adr = 4'd5; rst_n = 1'b0;
        step();
        rd = 1'b0;
        chk("rstrd.ack",   {31'b0, ack_o},     32'd0);
        chk("rstrd.dat",   dat_o,              32'h0);
        chk("rstrd.inv",   {31'b0, inverse_o}, 32'd0);
        chk("rstrd.src",   src_o,              32'h0);
        chk("rstrd.irq",   {31'b0, irq_o},     32'd0);
        rst_n = 1'b1;
        step();
        rd_chk("rstrd.size", 4'd2, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bel_fft_csr.md
Name: bel_fft_csr

Overview:
- Control/status register file that consumes the internal slave bus produced by the Avalon slave adapter (adr/dat/bsel/wr/rd in, dat/ack/err out).
- Holds FFT job configuration, issues the start pulse to the FFT core, collects done/error status, and drives the interrupt.
- Every access is acked exactly one cycle after its rd/wr strobe; the upstream adapter qualifies readdatavalid on that timing.

Parameters:
- DWIDTH, 32, bus data width in bits (BEL_FFT_DWIDTH).
- AWIDTH, 4, word address width (BEL_FFT_SIF_AWIDTH).
- MAX_LOG2, 10, largest supported FFT size as log2 points; the minimum is fixed at 3.
- CORE_ID, 32'hBE1F_0100, value returned by the ID register.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  synchronous reset, active-low
- adr_i  in  AWIDTH  word address
- dat_i  in  DWIDTH  write data
- bsel_i  in  DWIDTH/8  byte enables
- wr_i  in  1  write strobe, one cycle per access
- rd_i  in  1  read strobe, one cycle per access
- dat_o  out  DWIDTH  read data
- ack_o  out  1  access complete
- err_o  out  1  access error, only asserted together with ack_o
- start_o  out  1  one-cycle start pulse to the FFT core
- inverse_o  out  1  inverse-transform select
- size_log2_o  out  4  FFT size
- src_adr_o  out  DWIDTH  source buffer byte address
- dst_adr_o  out  DWIDTH  destination buffer byte address
- busy_i  in  1  core running
- done_i  in  1  one-cycle pulse, job finished
- cerr_i  in  1  one-cycle pulse, core bus error
- irq_o  out  1  interrupt, level

Behaviour:
- Register map (word address):
  - 0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IE, bit2 INVERSE.
  - 1 STATUS: bit0 BUSY (live busy_i, read-only), bit1 DONE (sticky, write-1-clear), bit2 CERR (sticky, W1C), bit3 OVR (sticky, W1C).
  - 2 SIZE: bits3:0 = log2 points.
  - 3 SRC, 4 DST: bits1:0 read 0, writes to them ignored.
  - 5 ID: read-only, returns CORE_ID.
  - 6..15: unmapped.
- Access pipeline: a strobe in cycle N gives ack_o=1 in N+1, with dat_o registered in N+1. Back-to-back strobes on consecutive cycles each get their own ack; no wait states. dat_o is 0 whenever ack_o=0 or the access is a write.
- rd_i and wr_i together in one cycle: treat as write, ack with err_o=1, registers unchanged.
- Byte enables apply per byte to CTRL, SIZE, SRC, DST and the STATUS W1C bits. A byte with bsel=0 is unaffected, including START.
- err_o=1 with ack in these cases:
  - any access to an unmapped address;
  - a write to ID;
  - a write to SIZE whose enabled low byte gives a value <3 or >MAX_LOG2. The register stays unchanged.
- START: writing 1 with busy_i=0 and no start pulse in the previous cycle gives start_o=1 in cycle N+1, exactly one cycle. START=1 while busy_i=1 or while a pulse is pending: no pulse, OVR set, ack without error.
- Configuration writes while busy_i=1 are accepted. The core latches its configuration on start_o, so these writes only affect the next job.
- Sticky bits: DONE set on done_i, CERR set on cerr_i. If a set event and a W1C of the same bit fall in the same cycle, the set wins.
- irq_o is registered: irq_o(N+1) = IE & (DONE|CERR) evaluated in N. Clearing IE or both sticky bits drops irq_o one cycle later.
- Reset (rst_n_i=0 at an edge):
  - all registers cleared, SIZE=3;
  - ack_o, err_o, start_o, irq_o, dat_o = 0;
  - a strobe coincident with reset is dropped (no ack).
  - Reset between a strobe and its ack cancels the ack.
- Outputs inverse_o, size_log2_o, src_adr_o, dst_adr_o are direct register values.

Decomposition:
- Register offsets, bit positions, MIN_LOG2=3 and the CTRL/STATUS field widths go in bel_fft_def.v as `defines, next to the existing width macros.
- No sub-module. A byte-masked write helper is a function local to this module.

Test Plan:
- Reset then read ID, SIZE, CTRL on consecutive cycles -> three acks on consecutive cycles, data BE1F0100, 3, 0, err_o=0.
- Write SRC=0x1000_0003 with bsel=4'b0011 -> SRC reads 0x0000_0000; then bsel=4'hF -> reads 0x1000_0000.
- Write CTRL=0x7 with busy_i=0 -> start_o high exactly one cycle, at ack; IE=1, INVERSE=1, CTRL reads 0x6. Repeat write with busy_i=1 -> no pulse, STATUS reads 0x9 (BUSY|OVR).
- done_i pulse with IE=1 -> DONE=1, irq_o=1 one cycle later. W1C DONE in the same cycle as a second done_i -> DONE stays 1. W1C alone -> irq_o=0 two cycles after the strobe.
- Write SIZE=2, then SIZE=11 (MAX_LOG2=10), read adr 9, write ID -> each acked with err_o=1; SIZE still reads 3.
- Assert rst_n_i=0 in the cycle after a read strobe -> no ack; all outputs 0; SIZE reads 3 after release.
